fpu_arbiter: RTL

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_arbiter_if.sv | 27 ++
 rtl/fpu_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester, response and FPU_top handshake signals of the FPU arbiter.
interface fpu_arbiter_if;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_lo, rsp_hi;
    logic [4:0]  fpu_op_mask;
    logic        fpu_instr_received;
    logic [31:0] fpu_input_1, fpu_input_2, fpu_reg_lo, fpu_reg_hi;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  fpu_reg_lo, fpu_reg_hi,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_lo, rsp_hi,
        output fpu_op_mask, fpu_instr_received, fpu_input_1, fpu_input_2
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output fpu_reg_lo, fpu_reg_hi,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_lo, rsp_hi,
        input  fpu_op_mask, fpu_instr_received, fpu_input_1, fpu_input_2
    );
endinterface

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one fixed-latency FPU_top between two requesters,
// one operation in flight at a time.
module fpu_arbiter #(
    parameter int LATENCY = 10
) (
    input logic          clk,
    input logic          rst_n,
    fpu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_last, r_gid, r_instr, r_rsp0, r_rsp1;
    logic [4:0]  r_op;
    logic [31:0] r_a, r_b, r_lo, r_hi;
    logic        w_idle, w_g0, w_g1;

    // r_last holds the previous grant; the other requester wins a tie
    always_comb begin
        w_idle = r_state == IDLE;
        w_g0   = w_idle & bus.req0_valid & (~bus.req1_valid | r_last);
        w_g1   = w_idle & bus.req1_valid & (~bus.req0_valid | ~r_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gid   <= 1'b0;
            r_instr <= 1'b0;
            r_rsp0  <= 1'b0;
            r_rsp1  <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_instr <= 1'b0;
            r_rsp0  <= 1'b0;
            r_rsp1  <= 1'b0;
            case (r_state)
                IDLE: if (w_g0 | w_g1) begin
                    r_state <= ISSUE;
                    r_gid   <= w_g1;
                    r_last  <= w_g1;
                    r_op    <= w_g1 ? bus.req1_op : bus.req0_op;
                    r_a     <= w_g1 ? bus.req1_a : bus.req0_a;
                    r_b     <= w_g1 ? bus.req1_b : bus.req0_b;
                    r_instr <= 1'b1;
                end
                ISSUE: begin
                    r_state <= WAIT;
                    r_cnt   <= '0;
                end
                WAIT: if (r_cnt == 8'(LATENCY - 1)) begin
                    r_lo    <= bus.fpu_reg_lo;
                    r_hi    <= bus.fpu_reg_hi;
                    r_rsp0  <= ~r_gid;
                    r_rsp1  <= r_gid;
                    r_state <= DONE;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready         = w_g0;
    assign bus.req1_ready         = w_g1;
    assign bus.rsp0_valid         = r_rsp0;
    assign bus.rsp1_valid         = r_rsp1;
    assign bus.rsp_lo             = r_lo;
    assign bus.rsp_hi             = r_hi;
    assign bus.fpu_op_mask        = r_op;
    assign bus.fpu_instr_received = r_instr;
    assign bus.fpu_input_1        = r_a;
    assign bus.fpu_input_2        = r_b;
endmodule
